// File: rtl/lstm_cell_seq.sv
// Streaming LSTM cell update: c_next = sig(f)*c_prev + sig(i)*tanh(g), h = sig(o)*tanh(c_next), N beats per run.
// Latency 3 cycles; one global stall (out_valid & ~out_ready) freezes every stage and deasserts in_ready.
module lstm_cell_seq #(
   parameter int N    = 100,
   parameter int DW   = 32,
   parameter int FRAC = 16,
   localparam int IW  = (N > 1) ? $clog2(N) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic signed [DW-1:0] in_c_prev,
   input  logic signed [DW-1:0] in_f,
   input  logic signed [DW-1:0] in_i,
   input  logic signed [DW-1:0] in_g,
   input  logic signed [DW-1:0] in_o,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic signed [DW-1:0] out_c_next,
   output logic signed [DW-1:0] out_h,
   output logic [IW-1:0]        out_idx,
   output logic                 out_last
);

   localparam logic signed [DW-1:0] ONE     = {{(DW-1){1'b0}}, 1'b1} << FRAC;
   localparam logic signed [DW-1:0] NEG_ONE = -ONE;
   localparam logic signed [DW:0]   ONE_W   = {1'b0, ONE};
   localparam logic signed [DW:0]   HALF_W  = ONE_W >>> 1;
   localparam logic signed [DW-1:0] MAXV    = {1'b0, {(DW-1){1'b1}}};
   localparam logic signed [DW-1:0] MINV    = {1'b1, {(DW-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   function automatic logic signed [DW-1:0] hsig(input logic signed [DW-1:0] x);
      logic signed [DW:0] t;
      t = $signed({x[DW-1], x}) >>> 2;
      t = t + HALF_W;
      if (t < 0)          return '0;
      else if (t > ONE_W) return ONE;
      else                return t[DW-1:0];
   endfunction

   function automatic logic signed [DW-1:0] htanh(input logic signed [DW-1:0] x);
      if (x > ONE)          return ONE;
      else if (x < NEG_ONE) return NEG_ONE;
      else                  return x;
   endfunction

   // Full-width product, rescaled, then saturated if the upper bits are not pure sign extension.
   function automatic logic signed [DW-1:0] mul(input logic signed [DW-1:0] a,
                                                input logic signed [DW-1:0] b);
      logic signed [2*DW-1:0] p;
      p = $signed({{DW{a[DW-1]}}, a}) * $signed({{DW{b[DW-1]}}, b});
      p = p >>> FRAC;
      if ((&p[2*DW-1:DW-1]) || (~|p[2*DW-1:DW-1])) return p[DW-1:0];
      else return p[2*DW-1] ? MINV : MAXV;
   endfunction

   function automatic logic signed [DW-1:0] add(input logic signed [DW-1:0] a,
                                                input logic signed [DW-1:0] b);
      logic signed [DW:0] s;
      s = $signed({a[DW-1], a}) + $signed({b[DW-1], b});
      if (s[DW] != s[DW-1]) return s[DW] ? MINV : MAXV;
      else                  return s[DW-1:0];
   endfunction

   state_t               state, state_nx;
   logic [IW-1:0]        in_cnt;
   logic                 stall, in_xfer, out_xfer;
   logic                 s1_vld, s2_vld;
   logic signed [DW-1:0] s1_sf, s1_si, s1_so, s1_tg, s1_cp;
   logic signed [DW-1:0] s2_c, s2_so;
   logic [IW-1:0]        s1_idx, s2_idx;

   assign stall    = out_valid & ~out_ready;
   assign in_ready = (state == RUN) & ~stall;
   assign in_xfer  = in_valid & in_ready;
   assign out_xfer = out_valid & out_ready;
   assign busy     = (state != IDLE);
   assign out_last = out_valid & (out_idx == IW'(N - 1));

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (in_xfer && (in_cnt == IW'(N - 1))) state_nx = DRAIN;
         DRAIN:   if (out_xfer && out_last) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         in_cnt <= '0;
         done   <= 1'b0;
      end else begin
         state <= state_nx;
         done  <= (state == DRAIN) && out_xfer && out_last;
         if (state == IDLE && start) in_cnt <= '0;
         else if (in_xfer)           in_cnt <= in_cnt + 1'b1;
      end
   end

   // Valid bits flow even in IDLE so a reset-free pipeline always drains.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld <= 1'b0; s1_sf <= '0; s1_si <= '0; s1_so <= '0; s1_tg <= '0; s1_cp <= '0;
         s1_idx <= '0;
         s2_vld <= 1'b0; s2_c <= '0; s2_so <= '0; s2_idx <= '0;
         out_valid <= 1'b0; out_c_next <= '0; out_h <= '0; out_idx <= '0;
      end else if (!stall) begin
         s1_vld <= in_xfer;
         if (in_xfer) begin
            s1_sf  <= hsig(in_f);
            s1_si  <= hsig(in_i);
            s1_so  <= hsig(in_o);
            s1_tg  <= htanh(in_g);
            s1_cp  <= in_c_prev;
            s1_idx <= in_cnt;
         end
         s2_vld <= s1_vld;
         if (s1_vld) begin
            s2_c   <= add(mul(s1_sf, s1_cp), mul(s1_si, s1_tg));
            s2_so  <= s1_so;
            s2_idx <= s1_idx;
         end
         out_valid <= s2_vld;
         if (s2_vld) begin
            out_c_next <= s2_c;
            out_h      <= mul(s2_so, htanh(s2_c));
            out_idx    <= s2_idx;
         end
      end
   end

endmodule
